// File: rtl/systolic_ctrl_4x4.sv
// Sequencer for a 4x4 broadcast matmul array: buffers A/B, clears the PEs, feeds K outer-product slices, flags done.
// Latency: start -> done = 2 + K + DRAIN_CYC cycles; every output is registered (one cycle behind the FSM state).
// Backpressure: none; start is ignored outside IDLE, loads are dropped while busy. SYSTOLIC_PERF_CNT_EN adds a busy-cycle counter.
module systolic_ctrl_4x4 #(
    parameter int DATA_W    = 8,
    parameter int K         = 4,
    parameter int DRAIN_CYC = 1,
    localparam int IDX_W    = (K > 1) ? $clog2(K) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_en,
    input  logic                ld_sel,
    input  logic [IDX_W-1:0]    ld_idx,
    input  logic [4*DATA_W-1:0] ld_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pe_clr,
    output logic [DATA_W-1:0]   a1,
    output logic [DATA_W-1:0]   a2,
    output logic [DATA_W-1:0]   a3,
    output logic [DATA_W-1:0]   a4,
    output logic [DATA_W-1:0]   b1,
    output logic [DATA_W-1:0]   b2,
    output logic [DATA_W-1:0]   b3,
    output logic [DATA_W-1:0]   b4,
    output logic [31:0]         perf_cycles
);

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [IDX_W-1:0] SLICE_LAST = IDX_W'(K - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   slice_q, slice_d;
    logic [DRN_W-1:0]   drain_q, drain_d;

    // buf_a[k][i] holds A[i][k] (column k of A); buf_b[k][j] holds B[k][j] (row k of B)
    logic [DATA_W-1:0]  buf_a [K][4];
    logic [DATA_W-1:0]  buf_b [K][4];

    logic               busy_q, done_q, pe_clr_q;
    logic [DATA_W-1:0]  a_q [4];
    logic [DATA_W-1:0]  b_q [4];
    logic               ld_ok;

    // Loads are gated by the registered busy flag so the host sees a consistent rule;
    // out-of-range indices (non-power-of-2 K) are discarded.
    assign ld_ok = ld_en && !busy_q && (int'(ld_idx) < K);

    // Operand buffers: written by the host while idle, persist across jobs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < K; k++) begin
                for (int i = 0; i < 4; i++) begin
                    buf_a[k][i] <= '0;
                    buf_b[k][i] <= '0;
                end
            end
        end else if (ld_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (!ld_sel) begin
                    buf_a[ld_idx][i] <= ld_data[DATA_W*i +: DATA_W];
                end else begin
                    buf_b[ld_idx][i] <= ld_data[DATA_W*i +: DATA_W];
                end
            end
        end
    end

    // FSM state and slice/drain counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            slice_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            slice_q <= slice_d;
            drain_q <= drain_d;
        end
    end

    // Next-state: CLEAR 1 cycle, FEED K cycles, DRAIN DRAIN_CYC cycles, DONE 1 cycle
    always_comb begin
        state_d = state_q;
        slice_d = slice_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                slice_d = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (slice_q == SLICE_LAST) begin
                    slice_d = '0;
                    drain_d = '0;
                    state_d = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
                end else begin
                    slice_d = slice_q + IDX_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                slice_d = '0;
                drain_d = '0;
            end
        endcase
    end

    // Registered outputs derived from the current state; operands are forced to 0 outside FEED
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pe_clr_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            busy_q   <= (state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN);
            done_q   <= (state_q == S_DONE);
            pe_clr_q <= (state_q == S_CLEAR);
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= (state_q == S_FEED) ? buf_a[slice_q][i] : '0;
                b_q[i] <= (state_q == S_FEED) ? buf_b[slice_q][i] : '0;
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign pe_clr = pe_clr_q;
    assign a1     = a_q[0];
    assign a2     = a_q[1];
    assign a3     = a_q[2];
    assign a4     = a_q[3];
    assign b1     = b_q[0];
    assign b2     = b_q[1];
    assign b3     = b_q[2];
    assign b4     = b_q[3];

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] perf_q;

    // Saturating count of cycles with busy high; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_ctrl_4x4.sv
// Bench for systolic_ctrl_4x4 with a behavioural 4x4 PE array model driven by the DUT outputs.
// Latency: checks start->done = 7 cycles for K=4, DRAIN_CYC=1.
// Backpressure: exercises start spamming, loads while busy and reset mid-job.
module tb_systolic_ctrl_4x4;

    logic        clk;
    logic        rst;
    logic        ld_en;
    logic        ld_sel;
    logic [1:0]  ld_idx;
    logic [31:0] ld_data;
    logic        start;
    logic        busy, done, pe_clr;
    logic [7:0]  a1, a2, a3, a4, b1, b2, b3, b4;
    logic [31:0] perf_cycles;
    logic [31:0] a_pk, b_pk;

    int n_chk  = 0;
    int n_fail = 0;

    systolic_ctrl_4x4 #(.DATA_W(8), .K(4), .DRAIN_CYC(1)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_idx(ld_idx),
        .ld_data(ld_data), .start(start), .busy(busy), .done(done), .pe_clr(pe_clr),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .b1(b1), .b2(b2), .b3(b3), .b4(b4),
        .perf_cycles(perf_cycles)
    );

    assign a_pk = {a4, a3, a2, a1};
    assign b_pk = {b4, b3, b2, b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Broadcast PE array model: poisoned by reset so only pe_clr can make it valid
    logic [31:0] acc [4][4];
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (!rst)        acc[i][j] <= 32'hDEADBEEF;
                else if (pe_clr) acc[i][j] <= 32'd0;
                else             acc[i][j] <= acc[i][j] + 32'(a_pk[8*i +: 8]) * 32'(b_pk[8*j +: 8]);
            end
        end
    end

    typedef struct {
        logic        start;
        logic        busy;
        logic        done;
        logic        pe_clr;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic sel, input int k, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_idx  = 2'(k);
        ld_data = d;
        tick();
        ld_en   = 1'b0;
        ld_data = 32'd0;
    endtask

    // A = identity, B[k][j] = 4k+j+1
    task automatic load_t1();
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            d = 32'h1 << (8 * k);
            load(1'b0, k, d);
            for (int j = 0; j < 4; j++) d[8*j +: 8] = 8'(4 * k + j + 1);
            load(1'b1, k, d);
        end
    endtask

    // mode 0: all zero, 1: C = B (4i+j+1), 2: all-ones operands (255*255*4)
    task automatic check_c(input int mode, input string tag);
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (mode)
                    0:       e = 32'd0;
                    1:       e = 32'(4 * i + j + 1);
                    default: e = 32'd260100;
                endcase
                chk($sformatf("%s_c%0d%0d", tag, i + 1, j + 1), acc[i][j], e);
            end
        end
    endtask

    // Pulses start, waits (bounded) for done; optionally pokes a load into column 3 of A mid-job
    task automatic run_job(input int poke, output int lat, output bit ok,
                           output int pe_cnt, output int nz_cnt);
        lat = 0; ok = 1'b0; pe_cnt = 0; nz_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (lat < 40) begin
            pe_cnt += int'(pe_clr);
            if ((a_pk | b_pk) != 32'd0) nz_cnt++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (lat == poke) begin
                ld_en = 1'b1; ld_sel = 1'b0; ld_idx = 2'd3; ld_data = 32'd0;
            end else begin
                ld_en = 1'b0;
            end
            tick();
            lat++;
        end
        ld_en = 1'b0;
    endtask

    // Cycle-by-cycle trace of one job; spam keeps start high through DONE
    task automatic run_table(input bit spam, input string tag);
        for (int r = 0; r < 9; r++) begin
            start = spam ? (r < 8) : tbl[r].start;
            tick();
            chk($sformatf("%s_r%0d_busy", tag, r),   32'(busy),   32'(tbl[r].busy));
            chk($sformatf("%s_r%0d_done", tag, r),   32'(done),   32'(tbl[r].done));
            chk($sformatf("%s_r%0d_peclr", tag, r),  32'(pe_clr), 32'(tbl[r].pe_clr));
            chk($sformatf("%s_r%0d_a", tag, r),      a_pk,        tbl[r].a);
            chk($sformatf("%s_r%0d_b", tag, r),      b_pk,        tbl[r].b);
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat, pe_cnt, nz_cnt, dcnt;
        bit          ok;
        logic [31:0] perf_exp;

        // row r is sampled after the r-th rising edge following the start request
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0403_0201};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0807_0605};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0C0B_0A09};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0100_0000, 32'h100F_0E0D};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};

`ifdef SYSTOLIC_PERF_CNT_EN
        perf_exp = 32'd12;
`else
        perf_exp = 32'd0;
`endif

        rst = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_idx = 2'd0; ld_data = 32'd0; start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_peclr",  32'(pe_clr), 32'd0);
        chk("rst_a",      a_pk,        32'd0);
        chk("rst_b",      b_pk,        32'd0);
        chk("rst_perf",   perf_cycles, 32'd0);
        rst = 1'b1;
        tick();

        // Buffers come out of reset zeroed; the job must also clear the poisoned accumulators
        run_job(-1, lat, ok, pe_cnt, nz_cnt);
        chk("j0_done_seen", 32'(ok),  32'd1);
        chk("j0_latency",   32'(lat), 32'd7);
        check_c(0, "j0");

        // Identity A: trace every cycle, then C must equal B
        load_t1();
        run_table(1'b0, "t1");
        check_c(1, "t1");

        // start held high through the job: one done, then nothing until a new start
        run_table(1'b1, "t3");
        check_c(1, "t3");
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            dcnt += int'(done) + int'(busy);
        end
        chk("t3_no_requeue", 32'(dcnt), 32'd0);
        run_job(-1, lat, ok, pe_cnt, nz_cnt);
        chk("t3_job2_latency", 32'(lat), 32'd7);
        check_c(1, "t3b");

        // Load of a zero column mid-FEED is dropped, in this job and the next
        run_job(3, lat, ok, pe_cnt, nz_cnt);
        chk("t4_latency", 32'(lat), 32'd7);
        check_c(1, "t4a");
        run_job(-1, lat, ok, pe_cnt, nz_cnt);
        check_c(1, "t4b");

        // All-ones operands: largest products, single clear pulse, operands only during FEED
        for (int k = 0; k < 4; k++) begin
            load(1'b0, k, 32'hFFFF_FFFF);
            load(1'b1, k, 32'hFFFF_FFFF);
        end
        run_job(-1, lat, ok, pe_cnt, nz_cnt);
        chk("t2_latency",  32'(lat),    32'd7);
        chk("t2_peclr_n",  32'(pe_cnt), 32'd1);
        chk("t2_feed_cyc", 32'(nz_cnt), 32'd4);
        check_c(2, "t2");

        // Reset while slice 2 is on the bus: outputs drop at once, no done follows
        load_t1();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t5_pre_a", a_pk, 32'h0001_0000);
        rst = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_a",    a_pk,      32'd0);
        chk("t5_b",    b_pk,      32'd0);
        tick();
        rst = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            dcnt += int'(done) + int'(busy);
        end
        chk("t5_no_done", 32'(dcnt), 32'd0);
        load_t1();
        run_job(-1, lat, ok, pe_cnt, nz_cnt);
        chk("t5_latency", 32'(lat), 32'd7);
        check_c(1, "t5");

        // Busy-cycle counter over two back-to-back jobs after a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t6_perf_rst", perf_cycles, 32'd0);
        run_job(-1, lat, ok, pe_cnt, nz_cnt);
        run_job(-1, lat, ok, pe_cnt, nz_cnt);
        chk("t6_job2_latency", 32'(lat), 32'd7);
        chk("t6_perf", perf_cycles, perf_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
